// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Moore control sequencer for fetch + ALU execute; define SEQ_MULDIV_EN to enable mul/div
module alu_op_sequencer #(
    parameter int NREGS        = 16,
    parameter int REGF_W       = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [31:0]       IR,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              LOin,
    output logic              HIin,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic [4:0]        opcode,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [4:0]         ir_op;
    logic [REGF_W-1:0]  ra, rb, rc;
    logic               alu_op, muldiv_op;
    logic               unused_ir;

    assign ir_op     = IR[31:27];
    assign ra        = IR[26 -: REGF_W];
    assign rb        = IR[22 -: REGF_W];
    assign rc        = IR[18 -: REGF_W];
    assign unused_ir = ^IR[14:0];
    assign alu_op    = (ir_op >= 5'd3) && (ir_op <= 5'd11);
    assign muldiv_op = (ir_op == 5'd15) || (ir_op == 5'd16);

    function automatic logic [NREGS-1:0] onehot(input logic [REGF_W-1:0] idx);
        onehot = {{(NREGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_ff @(posedge Clock) begin
        if (clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Counter only runs while stalled in T1, so it is zero on every T1 entry
            if (state == S_T1 && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        LOin = 1'b0; HIin = 1'b0;
        Rin = '0; Rout = '0; opcode = 5'd0;
        busy  = (state != S_IDLE);
        done  = 1'b0;
        error = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_ready)
                    state_nxt = S_T2;
                else if (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1))
                    state_nxt = S_ERR;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                Rout = onehot(rb); Yin = 1'b1;
`ifdef SEQ_MULDIV_EN
                state_nxt = (alu_op || muldiv_op) ? S_T4 : S_ERR;
`else
                state_nxt = alu_op ? S_T4 : S_ERR;
`endif
            end
            S_T4: begin
                Rout = onehot(rc); Zin = 1'b1; opcode = ir_op;
                state_nxt = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (muldiv_op) begin
                    LOin = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    Rin = onehot(ra);
                    state_nxt = S_DONE;
                end
`else
                Rin = onehot(ra);
                state_nxt = S_DONE;
`endif
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                error = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        Clock, clear, start, mem_ready;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    logic        busy, done, error;
    logic [13:0] strb;

    int checks = 0;
    int errors = 0;

    // Strobe order: PCout PCin IncPC MARin Read MDRin MDRout IRin Yin Zin Zlowout Zhighout LOin HIin
    localparam logic [13:0] S_NONE = 14'b00000000000000;
    localparam logic [13:0] S_T0   = 14'b10110000010000;
    localparam logic [13:0] S_T1   = 14'b01001100001000;
    localparam logic [13:0] S_T2   = 14'b00000011000000;
    localparam logic [13:0] S_T3   = 14'b00000000100000;
    localparam logic [13:0] S_T4   = 14'b00000000010000;
    localparam logic [13:0] S_T5   = 14'b00000000001000;
    localparam logic [13:0] S_T5M  = 14'b00000000001010;
    localparam logic [13:0] S_T6   = 14'b00000000000101;

    assign strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                   Yin, Zin, Zlowout, Zhighout, LOin, HIin};

    alu_op_sequencer dut (
        .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .Rin(Rin), .Rout(Rout), .opcode(opcode), .busy(busy), .done(done), .error(error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [13:0] es, input logic [15:0] erin,
                       input logic [15:0] erout, input logic [4:0] eop,
                       input logic ebusy, input logic edone, input logic eerr);
        checks++;
        assert (strb === es) else begin
            errors++; $error("FAIL %s strobes got %b exp %b", tag, strb, es);
        end
        checks++;
        assert (Rin === erin) else begin
            errors++; $error("FAIL %s Rin got %h exp %h", tag, Rin, erin);
        end
        checks++;
        assert (Rout === erout) else begin
            errors++; $error("FAIL %s Rout got %h exp %h", tag, Rout, erout);
        end
        checks++;
        assert (opcode === eop) else begin
            errors++; $error("FAIL %s opcode got %0d exp %0d", tag, opcode, eop);
        end
        checks++;
        assert (busy === ebusy) else begin
            errors++; $error("FAIL %s busy got %b exp %b", tag, busy, ebusy);
        end
        checks++;
        assert (done === edone) else begin
            errors++; $error("FAIL %s done got %b exp %b", tag, done, edone);
        end
        checks++;
        assert (error === eerr) else begin
            errors++; $error("FAIL %s error got %b exp %b", tag, error, eerr);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk(tag, S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fetch_chk(input string tag, input logic [15:0] rb_hot);
        chk({tag, "_t0"}, S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        chk({tag, "_t1"}, S_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        chk({tag, "_t2"}, S_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        chk({tag, "_t3"}, S_T3, 16'h0, rb_hot, 5'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; mem_ready = 1'b1; IR = 32'h0;
        tick(); tick();
        idle_chk("reset");
        clear = 1'b0;
        tick();
        idle_chk("idle");

        // ALU add-class op, opcode 5, Ra=1 Rb=2 Rc=3
        IR = 32'h28918000; start = 1'b1;
        tick(); start = 1'b0;
        fetch_chk("alu", 16'h0004); tick();
        chk("alu_t4", S_T4, 16'h0, 16'h0008, 5'd5, 1'b1, 1'b0, 1'b0); tick();
        chk("alu_t5", S_T5, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        chk("alu_done_c7", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
        idle_chk("alu_c8");

        // Memory stall: T1 held for cycles 2..5
        mem_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("wait_t0", S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 5) mem_ready = 1'b1;
            chk($sformatf("wait_t1_c%0d", c), S_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        end
        tick(); chk("wait_t2", S_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(); chk("wait_t3", S_T3, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(); chk("wait_t4", S_T4, 16'h0, 16'h0008, 5'd5, 1'b1, 1'b0, 1'b0);
        tick(); chk("wait_t5", S_T5, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(); chk("wait_done_c10", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick(); idle_chk("wait_c11");

        // Clear during a T1 stall
        mem_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("clrwait_t1", S_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick(); clear = 1'b0;
        idle_chk("clrwait_idle");

        // Stuck memory: 15 cycles in T1 then error
        start = 1'b1;
        tick(); start = 1'b0;
        chk("tmo_t0", S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk($sformatf("tmo_t1_c%0d", c), S_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        end
        tick(); chk("tmo_err", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b1);
        tick(); idle_chk("tmo_idle");
        mem_ready = 1'b1;

        // Illegal opcode 0
        IR = 32'h0; start = 1'b1;
        tick(); start = 1'b0;
        fetch_chk("op0", 16'h0001); tick();
        chk("op0_err", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b1); tick();
        idle_chk("op0_idle");

        // mul, opcode 15, Ra=0 Rb=3 Rc=4
        IR = 32'h781A0000; start = 1'b1;
        tick(); start = 1'b0;
        fetch_chk("mul", 16'h0008); tick();
`ifdef SEQ_MULDIV_EN
        chk("mul_t4", S_T4, 16'h0, 16'h0010, 5'd15, 1'b1, 1'b0, 1'b0); tick();
        chk("mul_t5", S_T5M, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        chk("mul_t6", S_T6, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        chk("mul_done_c8", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
`else
        chk("mul_err", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b1); tick();
`endif
        idle_chk("mul_idle");

        // Clear during T4 with start held high
        IR = 32'h28918000; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("clr_t4", S_T4, 16'h0, 16'h0008, 5'd5, 1'b1, 1'b0, 1'b0);
        clear = 1'b1; start = 1'b1;
        tick(); idle_chk("clr_idle1");
        tick(); idle_chk("clr_idle2");
        clear = 1'b0;
        tick();
        chk("clr_restart_t0", S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick(); tick(); tick();
        chk("clr_t5", S_T5, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick(); start = 1'b0;
        chk("clr_done_c7", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick(); idle_chk("clr_c8");
        tick(); idle_chk("clr_c9");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
